des_key_schedule: RTL and testbench
===================================

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 SHALL have no parameters; all widths are fixed by DES: 64-bit key, 48-bit round key, 16 rounds, 768-bit key bus.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request to begin key expansion; sampled only in IDLE.
REQ-005 key_i  input  64  DES key; DES bit 1 = key_i[63]; parity bits (8,16,...,64) are ignored.
REQ-006 busy  output  1  high while in GEN.
REQ-007 keys_valid  output  1  high when round_keys_o holds a complete, consistent schedule.
REQ-008 round_keys_o  output  768  round keys K1..K16 in encryption order; K1 at [767:720], K(n) at [767-48(n-1) -: 48], K16 at [47:0].

Function
REQ-009 SHALL implement FSM states IDLE, GEN and DONE.
REQ-010 Transitions SHALL be:
- IDLE -> GEN on start.
- GEN -> DONE after the 16th round key is written.
- DONE -> GEN on start.
- No transition otherwise.
REQ-011 On entering GEN, the block SHALL latch PC-1(key_i) into 28-bit registers C and D and clear the 4-bit round counter.
REQ-012 In each GEN cycle r (0..15):
- C and D SHALL rotate left by SHIFT[r], with SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- PC-2 of the rotated {C,D} SHALL be written to slot K(r+1) in the same cycle.
REQ-013 Latency SHALL be exactly 17 cycles from the start-sampling edge to keys_valid=1: 1 load edge, then 16 GEN edges.
REQ-014 keys_valid SHALL be 0 in IDLE and GEN, and 1 in DONE.
REQ-015 keys_valid SHALL drop to 0 on the edge that accepts a new start from DONE.
REQ-016 round_keys_o SHALL hold its value in DONE until the next GEN overwrites it slot by slot.
REQ-017 start while in GEN SHALL be ignored; the run in progress completes unchanged.
REQ-018 key_i SHALL be sampled only on the start-accepting edge; later changes to key_i do not affect the run.
REQ-019 start held high continuously SHALL cause back-to-back runs: DONE lasts exactly 1 cycle, then GEN begins again.
REQ-020 The round counter SHALL wrap only through the DONE transition and never index beyond slot 16.
REQ-021 busy SHALL equal (state == GEN).

Reset
REQ-022 While rst_n=0, the block SHALL be in IDLE with busy=0, keys_valid=0, round_keys_o=0, C=D=0 and counter=0.
REQ-023 An assertion of rst_n in the middle of GEN SHALL abort the run immediately; the partial schedule is never flagged valid.
REQ-024 After rst_n is released, the first start SHALL be honoured no earlier than the first rising clk edge.

Structure
REQ-025 A shared package des_pkg SHALL hold:
- the PC-1 table (56 entries) and PC-2 table (48 entries);
- the SHIFT table (16 entries);
- constants for round count (16), key width (48) and bus width (768).
REQ-026 The FSM state typedef SHALL be local to the module.
REQ-027 One sub-module SHALL be used: des_pc2, a purely combinational 56->48 permutation instantiated once.
REQ-028 PC-1 SHALL be implemented inline.
REQ-029 Output ordering SHALL match the key-bus convention consumed by the round-key mux, so that the decrypt direction is obtained purely by slot reversal downstream.

Verification
REQ-030 Test vector: key_i=0x133457799BBCDFF1, pulse start -> after 17 cycles keys_valid=1, with K1=0x1B02EFFC7072, K2=0x79AED9DBC9E5 and K16=0xCB3D8B0E17F5.
REQ-031 Parity check: key_i=0x133457799BBCDFF1 XOR 0x0101010101010101 -> round_keys_o identical to REQ-030.
REQ-032 start re-pulsed at cycle 5 of GEN with a different key_i -> ignored; REQ-030 values result; keys_valid still rises at cycle 17.
REQ-033 rst_n pulsed low at GEN cycle 8 -> busy=0, keys_valid=0 and round_keys_o=0 immediately; no keys_valid afterwards without a new start.
REQ-034 start held high for 40 cycles with key 0x0000000000000000 -> all slots 0; keys_valid high exactly at cycles 17 and 34 (1-cycle pulses); busy low only in those cycles.
REQ-035 Run key 0xFFFFFFFFFFFFFFFF, then 0x133457799BBCDFF1 from DONE -> keys_valid falls on the accept edge and rises again 17 cycles later with the REQ-030 values.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1, PC-2 and per-round rotation tables.
// DES bit numbering throughout: bit 1 is the MSB of the vector.
package des_pkg;

  localparam int NUM_ROUNDS = 16;
  localparam int RK_W       = 48;
  localparam int BUS_W      = 768;

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SHIFT_TBL [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Left rotation of a 28-bit key half by one or two places.
  function automatic logic [27:0] rotl28(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression: 56-bit {C,D} to a 48-bit round key, pure wiring.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd_i,
  output logic [47:0] k_o
);

  for (genvar j = 0; j < RK_W; j++) begin : g_pc2
    assign k_o[6'(47 - j)] = cd_i[6'(56 - PC2_TBL[j])];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one round key per GEN cycle, K1..K16 packed
// MSB-first on a 768-bit bus so decryption only needs slot reversal downstream.
module des_key_schedule
  import des_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [63:0]  key_i,
  output logic         busy,
  output logic         keys_valid,
  output logic [767:0] round_keys_o
);

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_e;

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [47:0] rk_q [NUM_ROUNDS];

  logic [55:0] pc1_key;
  logic [27:0] c_rot, d_rot;
  logic [47:0] rk_new;
  logic        shift_two;
  logic        load, gen_step;

  // PC-1 drops the parity bits (8,16,...,64) by never selecting them.
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_key[6'(55 - i)] = key_i[6'(64 - PC1_TBL[i])];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = GEN;
      GEN:     if (cnt_q == 4'd15) state_d = DONE;
      DONE:    if (start) state_d = GEN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == GEN);
    keys_valid = (state_q == DONE);
    load       = start && (state_q == IDLE || state_q == DONE);
    gen_step   = (state_q == GEN);
  end

  assign shift_two = (SHIFT_TBL[cnt_q] == 2);
  assign c_rot     = rotl28(c_q, shift_two);
  assign d_rot     = rotl28(d_q, shift_two);

  des_pc2 u_pc2 (
    .cd_i ({c_rot, d_rot}),
    .k_o  (rk_new)
  );

  always_comb begin
    c_d   = c_q;
    d_d   = d_q;
    cnt_d = cnt_q;
    if (load) begin
      c_d   = pc1_key[55:28];
      d_d   = pc1_key[27:0];
      cnt_d = '0;
    end else if (gen_step) begin
      c_d   = c_rot;
      d_d   = d_rot;
      cnt_d = cnt_q + 4'd1;
    end
  end

  // The counter wraps 15->0 exactly on the GEN->DONE edge, so slot 16 is the last written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
      for (int n = 0; n < NUM_ROUNDS; n++) rk_q[4'(n)] <= '0;
    end else begin
      c_q   <= c_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
      if (gen_step) rk_q[cnt_q] <= rk_new;
    end
  end

  always_comb begin
    round_keys_o = '0;
    for (int n = 0; n < NUM_ROUNDS; n++) begin
      round_keys_o = {round_keys_o[BUS_W-RK_W-1:0], rk_q[4'(n)]};
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: fixed DES vectors, protocol corner cases and
// random keys scored against a table-driven DES key-schedule model.
module tb_des_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [63:0]  key_i;
  logic         busy;
  logic         keys_valid;
  logic [767:0] round_keys_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [767:0] exp_q[$];

  localparam logic [63:0] TV_KEY = 64'h133457799BBCDFF1;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Clock and DUT
  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .key_i        (key_i),
    .busy         (busy),
    .keys_valid   (keys_valid),
    .round_keys_o (round_keys_o)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference model: full DES key schedule from the standard tables.
  function automatic logic [767:0] ref_sched(input logic [63:0] key);
    logic [767:0] bus;
    logic [55:0]  cd;
    logic [55:0]  ct;
    logic [63:0]  kt;
    logic [27:0]  c;
    logic [27:0]  d;
    logic [47:0]  k;
    bus = '0;
    cd  = '0;
    for (int i = 0; i < 56; i++) begin
      kt = key >> (64 - PC1[i]);
      cd = {cd[54:0], kt[0]};
    end
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        c = (c << 1) | (c >> 27);
        d = (d << 1) | (d >> 27);
      end
      cd = {c, d};
      k  = '0;
      for (int j = 0; j < 48; j++) begin
        ct = cd >> (56 - PC2[j]);
        k  = {k[46:0], ct[0]};
      end
      bus = {bus[719:0], k};
    end
    return bus;
  endfunction

  function automatic logic [47:0] slot(input logic [767:0] bus, input int n);
    logic [767:0] t;
    t = bus >> (48 * (16 - n));
    return t[47:0];
  endfunction

  task automatic check(input string tag, input logic [767:0] got, input logic [767:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [63:0] key);
    key_i = key;
    start = 1'b1;
    exp_q.push_back(ref_sched(key));
    tick();
    start = 1'b0;
    key_i = {$urandom, $urandom};
  endtask

  // first = edges already elapsed since (and including) the accept edge.
  task automatic wait_done(input string tag, input int first, input int inject);
    int cyc;
    logic [767:0] e;
    cyc = first;
    while (!keys_valid && cyc < 40) begin
      check({tag, "_busy"}, 768'(busy), 768'(1));
      if (cyc == inject) begin
        start = 1'b1;
        key_i = ~key_i;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    check({tag, "_latency"}, 768'(cyc), 768'(17));
    check({tag, "_busy_done"}, 768'(busy), 768'(0));
    check({tag, "_sb_nonempty"}, 768'(exp_q.size() != 0), 768'(1));
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    check({tag, "_keys"}, round_keys_o, e);
  endtask

  // Stimulus and scoreboard
  initial begin
    logic [767:0] prev;
    logic [767:0] nxt;
    logic [767:0] part;
    logic [767:0] ones;
    logic [767:0] keep_old;
    logic [63:0]  rk;
    logic         seen;
    logic         hit;
    int           j;

    rst_n = 1'b0;
    start = 1'b0;
    key_i = '0;
    tick();
    tick();
    check("rst_busy", 768'(busy), 768'(0));
    check("rst_valid", 768'(keys_valid), 768'(0));
    check("rst_keys", round_keys_o, '0);
    rst_n = 1'b1;
    tick();
    check("idle_valid", 768'(keys_valid), 768'(0));
    check("idle_busy", 768'(busy), 768'(0));

    start_run(TV_KEY);
    wait_done("tv", 1, 0);
    check("tv_k1", 768'(slot(round_keys_o, 1)), 768'(48'h1B02EFFC7072));
    check("tv_k2", 768'(slot(round_keys_o, 2)), 768'(48'h79AED9DBC9E5));
    check("tv_k16", 768'(slot(round_keys_o, 16)), 768'(48'hCB3D8B0E17F5));
    repeat (3) tick();
    check("done_hold_valid", 768'(keys_valid), 768'(1));
    check("done_hold_keys", round_keys_o, ref_sched(TV_KEY));

    start_run(TV_KEY ^ 64'h0101010101010101);
    wait_done("parity", 1, 0);
    check("parity_k1", 768'(slot(round_keys_o, 1)), 768'(48'h1B02EFFC7072));
    check("parity_k16", 768'(slot(round_keys_o, 16)), 768'(48'hCB3D8B0E17F5));

    start_run(TV_KEY);
    wait_done("gen_restart", 1, 5);
    check("gen_restart_k2", 768'(slot(round_keys_o, 2)), 768'(48'h79AED9DBC9E5));

    start_run(TV_KEY);
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 768'(busy), 768'(0));
    check("midrst_valid", 768'(keys_valid), 768'(0));
    check("midrst_keys", round_keys_o, '0);
    void'(exp_q.pop_back());
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (keys_valid) seen = 1'b1;
    end
    check("midrst_no_valid", 768'(seen), 768'(0));

    key_i = '0;
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      hit = (k == 17) || (k == 34);
      check("held_valid", 768'(keys_valid), 768'(hit));
      check("held_busy", 768'(busy), 768'(!hit));
      if (k == 17) check("held_zero_keys", round_keys_o, '0);
    end
    start = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = keys_valid;
    end
    check("held_finish", 768'(seen), 768'(1));

    start_run(64'hFFFFFFFFFFFFFFFF);
    wait_done("ones", 1, 0);
    ones = '1;
    check("ones_all", round_keys_o, ones);
    start_run(TV_KEY);
    check("accept_drop", 768'(keys_valid), 768'(0));
    wait_done("redo", 1, 0);
    check("redo_k1", 768'(slot(round_keys_o, 1)), 768'(48'h1B02EFFC7072));

    prev = ref_sched(TV_KEY);
    for (int t = 0; t < 8; t++) begin
      rk = {$urandom, $urandom};
      nxt = ref_sched(rk);
      j = $urandom_range(1, 15);
      start_run(rk);
      repeat (j) tick();
      keep_old = ones >> (48 * j);
      part = (nxt & ~keep_old) | (prev & keep_old);
      check("overwrite_partial", round_keys_o, part);
      wait_done("rand", j + 1, 0);
      prev = nxt;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
